// File: rtl/row_accumulator_if.sv
// Product-in / row-sum-out bundle for row_accumulator.
// Signal names keep the block's documented port names so waveforms match the datasheet.
interface row_accumulator_if #(
  parameter int PROD_WIDTH = 24,
  parameter int ACC_WIDTH  = 32,
  parameter int CNT_WIDTH  = 8
);
  logic [PROD_WIDTH-1:0] prod_i;
  logic                  prod_valid_i;
  logic                  prod_last_i;
  logic                  prod_ready_o;
  logic [ACC_WIDTH-1:0]  sum_o;
  logic [CNT_WIDTH-1:0]  cnt_o;
  logic                  sat_o;
  logic                  sum_valid_o;
  logic                  sum_ready_i;

  modport slave (
    input  prod_i, prod_valid_i, prod_last_i, sum_ready_i,
    output prod_ready_o, sum_o, cnt_o, sat_o, sum_valid_o
  );

  modport master (
    output prod_i, prod_valid_i, prod_last_i, sum_ready_i,
    input  prod_ready_o, sum_o, cnt_o, sat_o, sum_valid_o
  );
endinterface

// File: rtl/row_accumulator.sv
// Per-row saturating sum of unsigned products, one result per `last`,
// queued in a small output FIFO so the next row can accumulate under backpressure.
module row_accumulator #(
  parameter int DATA_WIDTH = 12,
  parameter int PROD_WIDTH = 2*DATA_WIDTH,
  parameter int ACC_WIDTH  = 32,
  parameter int CNT_WIDTH  = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  row_accumulator_if.slave   bus
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [ACC_WIDTH-1:0] sum;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 sat;
  } entry_t;

  logic [ACC_WIDTH-1:0] acc, acc_next;
  logic [CNT_WIDTH-1:0] cnt, cnt_next;
  logic                 sat, sat_next;
  logic [ACC_WIDTH:0]   sum_n;

  entry_t               mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [OCC_W-1:0]     fifo_count;
  logic                 accept, push, pop;
  entry_t               head;

  // Ready is a function of registered occupancy only, never of sum_ready_i.
  assign bus.prod_ready_o = !rst && (fifo_count != OCC_W'(FIFO_DEPTH));
  assign bus.sum_valid_o  = (fifo_count != '0);
  assign accept = bus.prod_valid_i && bus.prod_ready_o;
  assign push   = accept && bus.prod_last_i;
  assign pop    = bus.sum_valid_o && bus.sum_ready_i;

  assign head        = mem[rd_ptr];
  assign bus.sum_o   = head.sum;
  assign bus.cnt_o   = head.cnt;
  assign bus.sat_o   = head.sat;

  always_comb begin
    sum_n    = {1'b0, acc} + (ACC_WIDTH+1)'(bus.prod_i);
    acc_next = sum_n[ACC_WIDTH-1:0];
    sat_next = 1'b0;
    if (sum_n[ACC_WIDTH] || sat) begin
      acc_next = '1;
      sat_next = 1'b1;
    end
    cnt_next = (&cnt) ? cnt : cnt + CNT_WIDTH'(1);
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      cnt        <= '0;
      sat        <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (accept) begin
        if (bus.prod_last_i) begin
          acc <= '0;
          cnt <= '0;
          sat <= 1'b0;
        end else begin
          acc <= acc_next;
          cnt <= cnt_next;
          sat <= sat_next;
        end
      end
      if (push) begin
        mem[wr_ptr] <= '{sum: acc_next, cnt: cnt_next, sat: sat_next};
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + OCC_W'(1);
        2'b01:   fifo_count <= fifo_count - OCC_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end
endmodule

// File: tb/tb_row_accumulator.sv
// Scoreboard bench: a 32-bit and a 24-bit (saturation) instance share clock and reset.
module tb_row_accumulator;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  row_accumulator_if #(.ACC_WIDTH(32)) if0 ();
  row_accumulator_if #(.ACC_WIDTH(24)) if1 ();

  row_accumulator #(.ACC_WIDTH(32)) u0 (.clk(clk), .rst(rst), .bus(if0));
  row_accumulator #(.ACC_WIDTH(24)) u1 (.clk(clk), .rst(rst), .bus(if1));

  typedef struct {
    longint sum;
    int     cnt;
    bit     sat;
  } exp_t;

  exp_t   q0[$];
  exp_t   q1[$];
  longint m_acc [2];
  int     m_cnt [2];
  bit     m_sat [2];
  int     n_chk = 0;
  int     n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    else n_pass++;
  endtask

  // Reference behaviour of one accepted product for instance u.
  function automatic void model(input int u, input logic [23:0] p, input logic last);
    longint maxv = (u == 0) ? 64'hFFFF_FFFF : 64'hFF_FFFF;
    longint s    = m_acc[u] + longint'(p);
    exp_t   e;
    if (s > maxv || m_sat[u]) begin
      m_acc[u] = maxv;
      m_sat[u] = 1'b1;
    end else begin
      m_acc[u] = s;
    end
    if (m_cnt[u] < 255) m_cnt[u]++;
    if (last) begin
      e.sum = m_acc[u];
      e.cnt = m_cnt[u];
      e.sat = m_sat[u];
      if (u == 0) q0.push_back(e);
      else        q1.push_back(e);
      m_acc[u] = 0;
      m_cnt[u] = 0;
      m_sat[u] = 1'b0;
    end
  endfunction

  task automatic compare(input int u, input logic [63:0] s, input logic [63:0] c, input logic st);
    exp_t e;
    if ((u == 0 && q0.size() == 0) || (u == 1 && q1.size() == 0)) begin
      chk($sformatf("u%0d_unexpected_output", u), s, 64'hDEAD);
      return;
    end
    e = (u == 0) ? q0.pop_front() : q1.pop_front();
    chk($sformatf("u%0d_sum", u), s, 64'(e.sum));
    chk($sformatf("u%0d_cnt", u), c, 64'(e.cnt));
    chk($sformatf("u%0d_sat", u), 64'(st), 64'(e.sat));
  endtask

  // Monitor samples on the falling edge: these are the values the next rising edge acts on.
  always @(negedge clk) begin
    if (rst) begin
      for (int u = 0; u < 2; u++) begin
        m_acc[u] = 0;
        m_cnt[u] = 0;
        m_sat[u] = 1'b0;
      end
      q0.delete();
      q1.delete();
    end else begin
      if (if0.prod_valid_i && if0.prod_ready_o) model(0, if0.prod_i, if0.prod_last_i);
      if (if1.prod_valid_i && if1.prod_ready_o) model(1, if1.prod_i, if1.prod_last_i);
      if (if0.sum_valid_o && if0.sum_ready_i) compare(0, 64'(if0.sum_o), 64'(if0.cnt_o), if0.sat_o);
      if (if1.sum_valid_o && if1.sum_ready_i) compare(1, 64'(if1.sum_o), 64'(if1.cnt_o), if1.sat_o);
    end
  end

  task automatic send(input int u, input logic [23:0] p, input logic last, output int waits);
    bit ok = 1'b0;
    waits = 0;
    if (u == 0) begin
      if0.prod_valid_i = 1'b1; if0.prod_i = p; if0.prod_last_i = last;
    end else begin
      if1.prod_valid_i = 1'b1; if1.prod_i = p; if1.prod_last_i = last;
    end
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ((u == 0) ? if0.prod_ready_o : if1.prod_ready_o) begin
        ok = 1'b1;
        break;
      end
      waits++;
    end
    if (!ok) chk("send_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    if0.prod_valid_i = 1'b0; if0.prod_last_i = 1'b0;
    if1.prod_valid_i = 1'b0; if1.prod_last_i = 1'b0;
  endtask

  initial begin
    int w;
    rst = 1'b1;
    if0.prod_i = '0; if0.prod_valid_i = 1'b0; if0.prod_last_i = 1'b0; if0.sum_ready_i = 1'b0;
    if1.prod_i = '0; if1.prod_valid_i = 1'b0; if1.prod_last_i = 1'b0; if1.sum_ready_i = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready_low", 64'(if0.prod_ready_o), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 64'(if0.prod_ready_o), 64'd1);
    chk("post_rst_valid", 64'(if0.sum_valid_o), 64'd0);
    chk("post_rst_sum",   64'(if0.sum_o), 64'd0);
    chk("post_rst_cnt",   64'(if0.cnt_o), 64'd0);
    chk("post_rst_sat",   64'(if0.sat_o), 64'd0);
    chk("post_rst_ready1", 64'(if1.prod_ready_o), 64'd1);
    @(posedge clk); #1;

    // Single row 100+200+300, one-cycle latency, shown for exactly one cycle
    if0.sum_ready_i = 1'b1;
    send(0, 24'd100, 1'b0, w);
    send(0, 24'd200, 1'b0, w);
    send(0, 24'd300, 1'b1, w);
    idle();
    @(negedge clk);
    chk("row_latency_valid", 64'(if0.sum_valid_o), 64'd1);
    chk("row_latency_sum",   64'(if0.sum_o), 64'd600);
    @(negedge clk);
    chk("row_valid_drop", 64'(if0.sum_valid_o), 64'd0);
    @(posedge clk); #1;

    // One-element rows back to back
    send(0, 24'd16769025, 1'b1, w);
    chk("b2b_ready0", 64'(w), 64'd0);
    send(0, 24'd1, 1'b1, w);
    chk("b2b_ready1", 64'(w), 64'd0);
    idle();

    // Saturation on the 24-bit instance, then a clean row
    if1.sum_ready_i = 1'b1;
    send(1, 24'hFFFFFF, 1'b0, w);
    send(1, 24'd1, 1'b1, w);
    send(1, 24'd5, 1'b1, w);
    idle();
    repeat (3) @(posedge clk); #1;

    // Backpressure: two rows buffer, the third waits for a pop
    if0.sum_ready_i = 1'b0;
    send(0, 24'd7, 1'b1, w);
    send(0, 24'd8, 1'b1, w);
    if0.prod_valid_i = 1'b1; if0.prod_i = 24'd9; if0.prod_last_i = 1'b1;
    @(negedge clk);
    chk("bp_ready_low", 64'(if0.prod_ready_o), 64'd0);
    @(negedge clk);
    chk("bp_ready_held", 64'(if0.prod_ready_o), 64'd0);
    chk("bp_head_stable", 64'(if0.sum_o), 64'd7);
    @(posedge clk); #1;
    if0.sum_ready_i = 1'b1;
    send(0, 24'd9, 1'b1, w);
    chk("bp_ready_rise_after_pop", 64'(w), 64'd1);
    idle();
    repeat (4) @(posedge clk); #1;

    // Occupancy held at 1 by simultaneous push/pop across pointer wraps
    if0.sum_ready_i = 1'b0;
    send(0, 24'd1000, 1'b1, w);
    if0.sum_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(0, 24'(1001 + 3*i), 1'b1, w);
      chk($sformatf("stream_ready_%0d", i), 64'(w), 64'd0);
    end
    idle();
    @(negedge clk);
    chk("stream_one_left", 64'(if0.sum_valid_o), 64'd1);
    repeat (3) @(posedge clk); #1;

    // Reset mid-row discards the partial row
    send(0, 24'd10, 1'b0, w);
    send(0, 24'd20, 1'b0, w);
    idle();
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    send(0, 24'd3, 1'b1, w);
    idle();
    repeat (5) @(posedge clk);

    @(negedge clk);
    chk("q0_drained", 64'(q0.size()), 64'd0);
    chk("q1_drained", 64'(q1.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/row_accumulator.md
# row_accumulator

Streaming accumulator that sits directly downstream of the 12-bit product multipliers in the GAT datapath. It consumes a stream of unsigned 24-bit products, sums them per row (one row is delimited by a `last` flag), and emits one sum per row through a valid/ready output backed by a small FIFO. Typical uses are the feature·weight dot products and attention-score reductions. The output FIFO lets the next row accumulate while downstream stalls.

## Interface
Parameters:
- `DATA_WIDTH`, 12: multiplier operand width.
- `PROD_WIDTH`, 2*DATA_WIDTH: product width (24).
- `ACC_WIDTH`, 32: accumulator and sum width; must be ≥ PROD_WIDTH.
- `CNT_WIDTH`, 8: width of the per-row element counter.
- `FIFO_DEPTH`, 2: output FIFO entries; must be ≥ 1.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous active-high reset.
- `prod_i`  in  PROD_WIDTH  unsigned product from the multiplier.
- `prod_valid_i`  in  1  `prod_i` is valid this cycle.
- `prod_last_i`  in  1  `prod_i` is the final element of the row; qualified by `prod_valid_i`.
- `prod_ready_o`  out  1  block accepts a product this cycle.
- `sum_o`  out  ACC_WIDTH  row sum at the FIFO head.
- `cnt_o`  out  CNT_WIDTH  number of elements in that row (saturating).
- `sat_o`  out  1  row sum saturated.
- `sum_valid_o`  out  1  FIFO head is valid.
- `sum_ready_i`  in  1  downstream consumes the head.

## Operation
- A product is accepted when `prod_valid_i && prod_ready_o`.
- `prod_ready_o` = !rst && (fifo_count != FIFO_DEPTH). It depends only on registered state; there is no combinational path from `sum_ready_i`.
- Working registers: `acc` (ACC_WIDTH), `cnt` (CNT_WIDTH), `sat` (1). All are 0 after reset.
- On accept:
  - `sum_n` = acc + zero_extend(prod_i), computed ACC_WIDTH+1 bits wide.
  - If `sum_n` carries out or `sat` is already 1, then acc_next = all-ones and sat_next = 1. Saturation is sticky for the rest of the row.
  - cnt_next = cnt + 1, saturating at all-ones.
- Accept with `prod_last_i` = 1:
  - push {acc_next, cnt_next, sat_next} into the FIFO;
  - load `acc`, `cnt`, `sat` with 0 in the same cycle.
  - The next accepted product starts a fresh row with no bubble.
- Accept with `prod_last_i` = 0: update the working registers only.
- No accept: working registers hold their values.
- FIFO:
  - circular buffer with read/write pointers that wrap modulo FIFO_DEPTH, plus an occupancy counter `fifo_count` (0..FIFO_DEPTH);
  - `sum_valid_o` = (fifo_count != 0);
  - pop on `sum_valid_o && sum_ready_i`.
- Simultaneous push and pop: the occupancy count is unchanged and both pointers advance. A push never occurs when full, because ready was low at the start of that cycle. A pop when empty is ignored.
- `sum_o`, `cnt_o`, and `sat_o` reflect the head entry and are stable while `sum_valid_o && !sum_ready_i`.
- Reset mid-row or with the FIFO occupied discards the partial row and all queued sums. Nothing is emitted for them.

## Timing
- Reset values: `prod_ready_o`=0 while `rst` is high. In the first cycle after `rst` deasserts, `prod_ready_o`=1 and `sum_valid_o`=0. `sum_o`, `cnt_o`, and `sat_o` are 0 after reset.
- Latency: a last element accepted in cycle N gives `sum_valid_o`=1 in cycle N+1 with that row's sum.
- Throughput: one product per cycle sustained, provided downstream pops at least once per row.
- Backpressure:
  - With FIFO_DEPTH=2, two completed rows can be buffered.
  - `prod_ready_o` falls in the cycle after the second push if no pop occurred.
  - It rises in the cycle after a pop.
- `prod_i` and `prod_last_i` are ignored when `prod_valid_i`=0 or `prod_ready_o`=0.

## Test plan
- Single row: products 100, 200, 300 (last on 300) on consecutive cycles, `sum_ready_i`=1 → one cycle after the last, `sum_valid_o`=1 with `sum_o`=600, `cnt_o`=3, `sat_o`=0, held for 1 cycle.
- One-element rows back to back: products 4095*4095=16769025 (last) then 1 (last), with no bubble → sums 16769025 (cnt 1) then 1 (cnt 1) in order; `prod_ready_o` stays 1.
- Saturation: ACC_WIDTH=24 instance, products 0xFFFFFF then 1 (last) → `sum_o`=0xFFFFFF, `sat_o`=1. The next row with product 5 (last) → `sum_o`=5, `sat_o`=0.
- Backpressure: `sum_ready_i`=0, then push three one-element rows (7, 8, 9) → `prod_ready_o`=0 after the second push and 9 is not accepted. Raise `sum_ready_i` → pops give 7, then 8, and 9 is accepted once ready returns. No loss and no duplication.
- Simultaneous push/pop at FIFO_DEPTH=2 occupied with 1 entry → occupancy stays 1 and the pointers wrap correctly over 10 rows. Check the output sequence against the scoreboard.
- Reset mid-row: accept 10 and 20 (not last), assert `rst` for 1 cycle, then send 3 (last) → the only output is `sum_o`=3, `cnt_o`=1.
